// File: rtl/desc_rd_pkg.sv
// Shared types and constants for the descriptor readout engine.
// The state enum is exported so checkers can follow the FSM through dbg_state.
package desc_rd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_CAPT = 3'd2,
        ST_SEND = 3'd3,
        ST_FIN  = 3'd4
    } rd_state_e;

    localparam int DEF_CNT_DW = 16;
    localparam int DEF_DESC_W = 512;
    localparam int DEF_OUT_W  = 32;
    localparam int DEF_SEED_W = 9;

    // One header word followed by the descriptor slices.
    localparam int WORDS_PER_DESC = DEF_DESC_W / DEF_OUT_W + 1;

    localparam int HDR_IDX_LSB  = 16;
    localparam int HDR_FEAT_LSB = 0;

    // Cycles from valid_rd_desc to RAM data being valid.
    localparam int RD_LAT = 1;

    function automatic int words_per_desc(input int desc_w, input int out_w);
        return desc_w / out_w + 1;
    endfunction

endpackage

// File: rtl/desc_word_mux.sv
// Selects one stream word from the captured {feature, descriptor} pair.
// Word 0 is the header; words 1..N are descriptor slices, least significant first.
module desc_word_mux
    import desc_rd_pkg::*;
#(
    parameter int CNT_DW = DEF_CNT_DW,
    parameter int DESC_W = DEF_DESC_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SEED_W = DEF_SEED_W,
    parameter int WC_W   = 5
) (
    input  logic [CNT_DW+DESC_W-1:0] pair_buf,
    input  logic [SEED_W-1:0]        idx,
    input  logic [WC_W-1:0]          wc,
    output logic [OUT_W-1:0]         word
);

    always_comb begin
        word = '0;
        if (wc == '0) begin
            word[HDR_IDX_LSB +: SEED_W]  = idx;
            word[HDR_FEAT_LSB +: CNT_DW] = pair_buf[DESC_W +: CNT_DW];
        end else begin
            word = pair_buf[(int'(wc) - 1) * OUT_W +: OUT_W];
        end
    end

endmodule

// File: rtl/desc_reader.sv
// Walks descriptor indices 0..N-1 over the shared read port and streams each
// {feature, descriptor} pair as a header word plus descriptor slices.
module desc_reader
    import desc_rd_pkg::*;
#(
    parameter int CNT_DW = DEF_CNT_DW,
    parameter int DESC_W = DEF_DESC_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SEED_W = DEF_SEED_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEED_W-1:0] cnt_seed,
    output logic              valid_rd_desc,
    output logic [SEED_W-1:0] addr_rd_desc,
    input  logic [CNT_DW-1:0] data_rd_feature,
    input  logic [DESC_W-1:0] data_rd_desc,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_sop,
    output logic              m_eop,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output rd_state_e         dbg_state
);

    localparam int NWORDS = words_per_desc(DESC_W, OUT_W);
    localparam int WC_W   = $clog2(NWORDS);
    localparam int BUF_W  = CNT_DW + DESC_W;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(NWORDS - 1);

    rd_state_e           state_q, state_d;
    logic [SEED_W-1:0]   n_total_q, n_total_d;
    logic [SEED_W-1:0]   idx_q, idx_d;
    logic [WC_W-1:0]     wc_q, wc_d;
    logic [BUF_W-1:0]    pair_q, pair_d;
    logic [RD_LAT-1:0]   rd_pipe_q;

    logic                hs;
    logic                last_desc;
    logic [OUT_W-1:0]    word_d;

    logic                valid_rd_d;
    logic [SEED_W-1:0]   addr_rd_d;
    logic                m_valid_d;
    logic [OUT_W-1:0]    m_data_d;
    logic                m_sop_d;
    logic                m_eop_d;
    logic                m_last_d;
    logic                busy_d;
    logic                done_d;

    // Stream handshake: a word transfers on a cycle where m_valid && m_ready.
    // Once m_valid is high, m_data and the sop/eop/last flags hold until that
    // transfer, and m_valid never drops without it.
    assign hs        = m_valid && m_ready;
    assign last_desc = (idx_q == n_total_q - SEED_W'(1));
    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_total_d = n_total_q;
        idx_d     = idx_q;
        wc_d      = wc_q;
        pair_d    = pair_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_total_d = cnt_seed;
                    idx_d     = '0;
                    state_d   = (cnt_seed == '0) ? ST_FIN : ST_READ;
                end
            end
            ST_READ: state_d = ST_CAPT;
            ST_CAPT: begin
                if (rd_pipe_q[RD_LAT-1]) begin
                    pair_d  = {data_rd_feature, data_rd_desc};
                    wc_d    = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (hs) begin
                    if (wc_q == WC_LAST) begin
                        if (last_desc) begin
                            state_d = ST_FIN;
                        end else begin
                            idx_d   = idx_q + SEED_W'(1);
                            state_d = ST_READ;
                        end
                    end else begin
                        wc_d = wc_q + WC_W'(1);
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    desc_word_mux #(
        .CNT_DW (CNT_DW),
        .DESC_W (DESC_W),
        .OUT_W  (OUT_W),
        .SEED_W (SEED_W),
        .WC_W   (WC_W)
    ) u_word_mux (
        .pair_buf (pair_d),
        .idx      (idx_d),
        .wc       (wc_d),
        .word     (word_d)
    );

    // Outputs are computed from next-state values so every port is a flop.
    always_comb begin
        valid_rd_d = (state_d == ST_READ);
        addr_rd_d  = (state_d == ST_READ) ? idx_d : addr_rd_desc;
        m_valid_d  = (state_d == ST_SEND);
        m_sop_d    = m_valid_d && (wc_d == '0);
        m_eop_d    = m_valid_d && (wc_d == WC_LAST);
        m_last_d   = m_eop_d && (idx_d == n_total_d - SEED_W'(1));
        m_data_d   = m_valid_d ? word_d : '0;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_total_q     <= '0;
            idx_q         <= '0;
            wc_q          <= '0;
            pair_q        <= '0;
            rd_pipe_q     <= '0;
            valid_rd_desc <= 1'b0;
            addr_rd_desc  <= '0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            m_sop         <= 1'b0;
            m_eop         <= 1'b0;
            m_last        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            n_total_q     <= n_total_d;
            idx_q         <= idx_d;
            wc_q          <= wc_d;
            pair_q        <= pair_d;
            rd_pipe_q     <= (rd_pipe_q << 1) | RD_LAT'(valid_rd_desc);
            valid_rd_desc <= valid_rd_d;
            addr_rd_desc  <= addr_rd_d;
            m_valid       <= m_valid_d;
            m_data        <= m_data_d;
            m_sop         <= m_sop_d;
            m_eop         <= m_eop_d;
            m_last        <= m_last_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

endmodule

// File: tb/tb_desc_reader.sv
// Bench for desc_reader: RAM model, expected-word scoreboard and a negedge monitor.
// Directed runs cover ready-high, empty, stalled, ignored-restart, mid-run reset and full-size readouts.
module tb_desc_reader;
    import desc_rd_pkg::*;

    localparam int CNT_DW = 16;
    localparam int DESC_W = 512;
    localparam int OUT_W  = 32;
    localparam int SEED_W = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [SEED_W-1:0] cnt_seed = '0;
    logic              valid_rd_desc;
    logic [SEED_W-1:0] addr_rd_desc;
    logic [CNT_DW-1:0] data_rd_feature = '0;
    logic [DESC_W-1:0] data_rd_desc = '0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [OUT_W-1:0]  m_data;
    logic              m_sop, m_eop, m_last;
    logic              busy, done;
    rd_state_e         dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int done_cyc  = 0;
    int done_cnt  = 0;
    int words_seen = 0;
    int last_cnt   = 0;
    bit rand_ready = 1'b0;

    logic [34:0]       exp_q[$];
    logic [31:0]       word_log[$];
    logic [31:0]       hdr_log[$];
    logic [SEED_W-1:0] rd_log[$];

    desc_reader dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cnt_seed        (cnt_seed),
        .valid_rd_desc   (valid_rd_desc),
        .addr_rd_desc    (addr_rd_desc),
        .data_rd_feature (data_rd_feature),
        .data_rd_desc    (data_rd_desc),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .m_sop           (m_sop),
        .m_eop           (m_eop),
        .m_last          (m_last),
        .busy            (busy),
        .done            (done),
        .dbg_state       (dbg_state)
    );

    // clock / reset-independent infrastructure
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] feat_of(input int i);
        return 16'(32'h1000 + i * 32'h0101);
    endfunction

    function automatic logic [31:0] desc_word(input int i, input int k);
        logic [3:0] kk = 4'(k - 1);
        logic [8:0] ii = 9'(i);
        logic [7:0] nx = 8'(i + 1);
        return {4'hD, kk, 7'd0, ii, nx};
    endfunction

    function automatic logic [DESC_W-1:0] desc_of(input int i);
        logic [DESC_W-1:0] d = '0;
        for (int k = 1; k < WORDS_PER_DESC; k++) d[32*(k-1) +: 32] = desc_word(i, k);
        return d;
    endfunction

    // Descriptor/feature RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (valid_rd_desc) begin
            data_rd_feature <= feat_of(int'(addr_rd_desc));
            data_rd_desc    <= desc_of(int'(addr_rd_desc));
        end
    end

    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard: expected words pushed when a run is issued
    task automatic push_expected(input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < WORDS_PER_DESC; k++) begin
                logic [31:0] d;
                logic sop, eop, lst;
                d   = (k == 0) ? {7'd0, 9'(i), feat_of(i)} : desc_word(i, k);
                sop = (k == 0);
                eop = (k == WORDS_PER_DESC - 1);
                lst = eop && (i == n - 1);
                exp_q.push_back({lst, eop, sop, d});
            end
        end
    endtask

    task automatic clear_logs();
        word_log.delete();
        hdr_log.delete();
        rd_log.delete();
        words_seen = 0;
        last_cnt   = 0;
    endtask

    // monitor
    bit          prev_stall = 1'b0;
    logic [34:0] prev_word  = '0;
    bit          done_pend  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            done_pend  = 1'b0;
        end else begin
            if (done_pend) begin
                chk("done_pulse_busy_fall", {62'd0, done, busy}, 64'd0);
                done_pend = 1'b0;
            end
            if (prev_stall)
                chk("stall_hold", {28'd0, m_valid, m_last, m_eop, m_sop, m_data},
                    {28'd0, 1'b1, prev_word});
            if (valid_rd_desc) rd_log.push_back(addr_rd_desc);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_word", {32'd0, m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [34:0] e;
                    e = exp_q.pop_front();
                    chk("stream_word", {29'd0, m_last, m_eop, m_sop, m_data}, {29'd0, e});
                end
                word_log.push_back(m_data);
                if (m_sop) hdr_log.push_back(m_data);
                if (m_last) last_cnt++;
                words_seen++;
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_last, m_eop, m_sop, m_data};
            if (done) begin
                done_cnt++;
                done_cyc = cyc - start_cyc;
                chk("busy_at_done", {63'd0, busy}, 64'd1);
                done_pend = 1'b1;
            end
        end
    end

    // driver: issue a run and wait (bounded) for done; optionally poke start/cnt_seed mid-run
    task automatic run(input int n, input bit rnd, input int poke_at, input int budget);
        int d0;
        bit got, poked;
        clear_logs();
        push_expected(n);
        rand_ready = rnd;
        d0 = done_cnt;
        got = 1'b0;
        poked = 1'b0;
        cnt_seed = SEED_W'(n);
        start = 1'b1;
        start_cyc = cyc;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done_cnt != d0) begin
                got = 1'b1;
                break;
            end
            if (poke_at >= 0 && !poked && words_seen >= poke_at) begin
                start    = 1'b1;
                cnt_seed = 9'd7;
                poked    = 1'b1;
            end
        end
        start = 1'b0;
        rand_ready = 1'b0;
        chk("done_seen", {63'd0, got}, 64'd1);
        chk("word_count", 64'(words_seen), 64'(n * WORDS_PER_DESC));
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        chk("last_count", 64'(last_cnt), (n > 0) ? 64'd1 : 64'd0);
        chk("read_count", 64'(rd_log.size()), 64'(n));
        for (int i = 0; i < n && i < rd_log.size(); i++)
            chk("read_addr", 64'(rd_log[i]), 64'(i));
        if (!rnd) chk("done_cycle", 64'(done_cyc), 64'(n * 19 + 1));
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
    endtask

    task automatic run_reset();
        bit hit;
        clear_logs();
        push_expected(3);
        cnt_seed = 9'd3;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (words_seen >= 24) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("reset_point_reached", {63'd0, hit}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs",
            {valid_rd_desc, addr_rd_desc, m_valid, m_data, m_sop, m_eop, m_last, busy, done},
            64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_activity", {61'd0, m_valid, busy, valid_rd_desc}, 64'd0);
        chk("rst_words_frozen", 64'(words_seen), 64'd24);
        chk("rst_reads_frozen", 64'(rd_log.size()), 64'd2);
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {valid_rd_desc, addr_rd_desc, m_valid, m_data, m_sop, m_eop, m_last, busy, done},
            64'd0);
        chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b0;
        @(posedge clk);
        #1;

        run(3, 1'b0, -1, 300);
        chk("hdr0", 64'((hdr_log.size() > 0) ? hdr_log[0] : 32'hDEAD), 64'h0000_1000);
        chk("hdr1", 64'((hdr_log.size() > 1) ? hdr_log[1] : 32'hDEAD), 64'h0001_1101);
        chk("hdr2", 64'((hdr_log.size() > 2) ? hdr_log[2] : 32'hDEAD), 64'h0002_1202);
        chk("word1", 64'((word_log.size() > 1) ? word_log[1] : 32'hDEAD), 64'hD000_0001);
        chk("word51", 64'((word_log.size() > 50) ? word_log[50] : 32'hDEAD), 64'hDF00_0203);

        run(0, 1'b0, -1, 50);

        run(5, 1'b1, -1, 3000);

        run(4, 1'b0, 20, 500);

        run_reset();
        run(3, 1'b0, -1, 300);
        chk("replay_hdr0", 64'((hdr_log.size() > 0) ? hdr_log[0] : 32'hDEAD), 64'h0000_1000);

        run(511, 1'b0, -1, 12000);
        w = (hdr_log.size() > 0) ? hdr_log[hdr_log.size() - 1] : 32'hFFFF_FFFF;
        chk("final_hdr_idx", 64'(w[24:16]), 64'h1FE);
        chk("final_read_addr", 64'((rd_log.size() > 0) ? rd_log[rd_log.size() - 1] : 9'd0), 64'd510);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/desc_reader.md
# desc_reader

Readout engine for the descriptor store of the SIFT pipeline. After the descriptor stage signals completion, it walks descriptor indices 0..N-1 through the stage's shared read port. For each keypoint it fetches the 16-bit feature address and the 512-bit descriptor. It serialises each pair into a 17-word, 32-bit valid/ready stream for the host-side DMA/UART path.

## Interface
Parameters:
- CNT_DW, 16, feature-address width (row*WIDE+col)
- DESC_W, 512, descriptor width
- OUT_W, 32, stream word width; DESC_W must be a multiple of OUT_W
- SEED_W, 9, descriptor index width

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse from the descriptor stage's valid_end
- cnt_seed  in  SEED_W  number of stored descriptors; sampled on start
- valid_rd_desc  out  1  read enable to the descriptor/feature RAMs
- addr_rd_desc  out  SEED_W  read index
- data_rd_feature  in  CNT_DW  feature address, valid 1 cycle after valid_rd_desc
- data_rd_desc  in  DESC_W  descriptor, valid 1 cycle after valid_rd_desc
- m_valid  out  1  stream word valid
- m_ready  in  1  downstream accept
- m_data  out  OUT_W  stream word
- m_sop  out  1  high on header word of each descriptor
- m_eop  out  1  high on last word of each descriptor
- m_last  out  1  high on final word of final descriptor
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when readout completes

## Operation
- FSM states: IDLE, READ, CAPT, SEND, FIN.
- IDLE: on start, latch cnt_seed into n_total and clear idx. If n_total==0, go to FIN. Otherwise go to READ.
- READ: valid_rd_desc=1 and addr_rd_desc=idx for exactly one cycle. Then go to CAPT.
- CAPT: RAM outputs are valid. Latch {data_rd_feature, data_rd_desc} into a 528-bit buffer, clear word counter wc, go to SEND.
- SEND: m_valid=1.
  - wc==0: m_data = {7'd0, idx[8:0], feature[15:0]}.
  - wc=k (1..16): m_data = desc[32k-1:32(k-1)], LSB slice first.
  - wc advances only on m_valid&&m_ready.
  - On accepting wc==16: if idx==n_total-1, go to FIN; else idx++ and go to READ.
- FIN: done=1 for one cycle, then go to IDLE.
- start is ignored while busy. cnt_seed changes after start are ignored.
- valid_rd_desc is never asserted outside READ, so the shared seed-read port upstream is never contended.
- AXI-stream rules: once m_valid rises, m_data/m_sop/m_eop/m_last hold stable until accepted. m_valid does not drop without a handshake.
- m_sop = (wc==0). m_eop = (wc==16). m_last = m_eop && idx==n_total-1.
- cnt_seed is 9 bits, so n_total is at most 511 and idx never wraps.

## Timing
- Reset values: valid_rd_desc=0, addr_rd_desc=0, m_valid=0, m_data=0, m_sop/m_eop/m_last=0, busy=0, done=0. State=IDLE, buffer cleared.
- Reset mid-readout aborts immediately with no further handshakes. A new start is required afterwards.
- All outputs are registered.
- Cycle map, with start sampled at cycle 0:
  - cycle 1: READ, idx 0.
  - cycle 2: CAPT.
  - cycle 3: first m_valid.
- With m_ready held high:
  - each descriptor takes 19 cycles (1 READ + 1 CAPT + 17 SEND);
  - next READ is in the cycle after the eop handshake;
  - done is in the cycle after the m_last handshake;
  - busy falls together with done's deassertion.
- n_total==0: busy at cycle 1 (FIN), done at cycle 1, no reads, no stream words.

## Structure
- Package desc_rd_pkg:
  - state enum;
  - WORDS_PER_DESC = DESC_W/OUT_W + 1 (17);
  - header field positions (idx [24:16], feature [15:0]);
  - RD_LAT = 1.
- Sub-module desc_word_mux: combinational selection of the 32-bit word from the 528-bit buffer by wc. It is the natural split; the FSM, counters and registers stay in desc_reader.

## Test plan
- cnt_seed=3, m_ready=1, RAM model with desc[i] = {16{i,i+1}} style patterns:
  - exactly 51 words;
  - headers 0x0000_xxxx, 0x0001_xxxx, 0x0002_xxxx with the correct feature values;
  - m_last only on word 51;
  - done at cycle 58.
- cnt_seed=0 -> no valid_rd_desc, no m_valid, done pulse at cycle 1.
- Random m_ready (50%) with cnt_seed=5:
  - m_data is stable during every stall;
  - word order is identical to the m_ready=1 run;
  - valid_rd_desc is asserted exactly 5 times with addresses 0..4.
- start re-pulsed during SEND and cnt_seed changed mid-run -> ignored; output is unchanged.
- rst asserted at word 7 of descriptor 1 -> all outputs zero immediately. A fresh start then replays from idx 0 correctly.
- cnt_seed=511, m_ready=1:
  - final header idx = 0x1FE;
  - 8687 words in total;
  - no wrap of idx.
